// File: rtl/spin_ctrl_pkg.sv
// Shared definitions for the spinner: ring geometry, timing constants,
// LFSR seed/taps and the controller state encoding.
package spin_ctrl_pkg;

  localparam int unsigned NUM_POS = 6;
  localparam int unsigned POS_W   = 3;
  localparam int unsigned PER_W   = 16;
  localparam int unsigned REM_W   = 5;
  localparam int unsigned LFSR_W  = 8;

  localparam logic [PER_W-1:0]  PERIOD_MIN = 16'd4;
  localparam logic [PER_W-1:0]  PERIOD_INC = 16'd2;
  localparam logic [PER_W-1:0]  PERIOD_MAX = '1;
  localparam logic [REM_W-1:0]  MIN_STEPS  = 5'd12;

  // x^8+x^6+x^5+x^4+1 : feedback from bits 7,5,4,3 of a left-shifting register
  localparam logic [LFSR_W-1:0] LFSR_SEED  = 8'hA5;
  localparam logic [LFSR_W-1:0] LFSR_TAPS  = 8'hB8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SPIN = 1'b1
  } state_e;

  // Next ring position with wrap from NUM_POS-1 back to 0
  function automatic logic [POS_W-1:0] next_pos(input logic [POS_W-1:0] p);
    return (p == POS_W'(NUM_POS - 1)) ? '0 : p + POS_W'(1);
  endfunction

endpackage

// File: rtl/spin_ctrl_if.sv
// Start/stop request and position/running/done status between the spin
// controller (master) and its consumers (slave).
// stop_i exists only when SPIN_STOP_EN is defined.
interface spin_ctrl_if;
  import spin_ctrl_pkg::*;

  logic             start_i;
`ifdef SPIN_STOP_EN
  logic             stop_i;
`endif
  logic [POS_W-1:0] pos_o;
  logic             running_o;
  logic             done_o;

  modport master (
`ifdef SPIN_STOP_EN
    input  stop_i,
`endif
    input  start_i,
    output pos_o,
    output running_o,
    output done_o
  );

  modport slave (
`ifdef SPIN_STOP_EN
    output stop_i,
`endif
    output start_i,
    input  pos_o,
    input  running_o,
    input  done_o
  );

endinterface

// File: rtl/spin_lfsr.sv
// 8-bit Fibonacci LFSR, free-running every cycle, reseeded on reset.
module spin_lfsr
  import spin_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  output logic [LFSR_W-1:0] lfsr_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic              fb_c;

  assign fb_c   = ^(lfsr_q & LFSR_TAPS);
  assign lfsr_o = lfsr_q;

  // Shift left with parity of the tapped bits into bit 0
  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= {lfsr_q[LFSR_W-2:0], fb_c};
  end

endmodule

// File: rtl/spin_ctrl.sv
// Spin controller: on start, steps an LED around a NUM_POS ring with a
// linearly growing step period, stopping after a pseudo-random step count.
// Optional early stop via stop_i when SPIN_STOP_EN is defined.
module spin_ctrl
  import spin_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  spin_ctrl_if.master bus
);

  logic [3:0]        lfsr_lo;
  logic [3:0]        lfsr_hi_unused;

  state_e            state_q;
  logic [POS_W-1:0]  pos_q;
  logic              running_q;
  logic              done_q;
  logic [PER_W-1:0]  cnt_q;
  logic [PER_W-1:0]  period_q;
  logic [PER_W-1:0]  period_d;
  logic [REM_W-1:0]  rem_q;
  logic [REM_W-1:0]  rem_d;
  logic              step_c;

  spin_lfsr u_lfsr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .lfsr_o ({lfsr_hi_unused, lfsr_lo})
  );

  assign bus.pos_o     = pos_q;
  assign bus.running_o = running_q;
  assign bus.done_o    = done_q;

  // Step detection, saturating period growth and remaining-step update
  always_comb begin
    step_c   = (state_q == ST_SPIN) && (cnt_q == period_q - PER_W'(1));
    period_d = (period_q > (PERIOD_MAX - PERIOD_INC)) ? PERIOD_MAX
                                                      : period_q + PERIOD_INC;
    rem_d    = step_c ? rem_q - REM_W'(1) : rem_q;
`ifdef SPIN_STOP_EN
    // Early stop clamps to two more steps, after any same-cycle decrement
    if (bus.stop_i && (rem_d > REM_W'(2))) rem_d = REM_W'(2);
`endif
  end

  // Controller FSM with registered position and status outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      pos_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      period_q  <= PERIOD_MIN;
      rem_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start_i) begin
            rem_q     <= MIN_STEPS + REM_W'(lfsr_lo);
            period_q  <= PERIOD_MIN;
            cnt_q     <= '0;
            state_q   <= ST_SPIN;
            running_q <= 1'b1;
          end
        end
        ST_SPIN: begin
          rem_q <= rem_d;
          if (step_c) begin
            pos_q    <= next_pos(pos_q);
            cnt_q    <= '0;
            period_q <= period_d;
            if (rem_q == REM_W'(1)) begin
              state_q   <= ST_IDLE;
              running_q <= 1'b0;
              done_q    <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + PER_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spin_ctrl.sv
// Directed testbench for spin_ctrl. Define SPIN_STOP_EN to also exercise stop_i.
module tb_spin_ctrl;
  import spin_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spin_ctrl_if sif ();

  spin_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (sif)
  );

  int checks = 0;
  int errors = 0;

  // Reference LFSR, used only to predict step counts of later spins
  logic [7:0] m_lfsr;
  always @(posedge clk) begin
    if (rst) m_lfsr <= 8'hA5;
    else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  int step_t[$];
  int step_p[$];
  int run_cycles;
  int dones;
  int exp_steps;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int spin_len(input int n);
    return 4 * n + n * (n - 1);
  endfunction

  // Pulse start for one edge, predicting the step count from the reference LFSR
  task automatic start_spin;
    exp_steps = 12 + int'(m_lfsr[3:0]);
    sif.start_i = 1'b1;
    tick();
    sif.start_i = 1'b0;
  endtask

  // Record step times/positions from the start edge until running drops
  task automatic measure(input int inj0, input int inj1, input int inj2, input int stop_at);
    int t;
    logic [POS_W-1:0] prev;
    t = 0;
    prev = sif.pos_o;
    step_t.delete();
    step_p.delete();
    run_cycles = 0;
    dones = 0;
    if (sif.running_o === 1'b1) run_cycles++;
    while (sif.running_o === 1'b1 && t < 3000) begin
      sif.start_i = (t + 1 == inj0) || (t + 1 == inj1) || (t + 1 == inj2);
`ifdef SPIN_STOP_EN
      sif.stop_i = (t + 1 == stop_at);
`endif
      tick();
      t++;
      sif.start_i = 1'b0;
`ifdef SPIN_STOP_EN
      sif.stop_i = 1'b0;
`endif
      if (sif.pos_o !== prev) begin
        step_t.push_back(t);
        step_p.push_back(int'(sif.pos_o));
        prev = sif.pos_o;
      end
      if (sif.running_o === 1'b1) run_cycles++;
      if (sif.done_o === 1'b1) dones++;
    end
    if (stop_at < 0) begin end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    checks++; if (sif.pos_o !== 3'd0) begin errors++; $display("FAIL reset_pos got %0d want 0", sif.pos_o); end
    checks++; if (sif.running_o !== 1'b0) begin errors++; $display("FAIL reset_running got %0b want 0", sif.running_o); end
    checks++; if (sif.done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", sif.done_o); end
  endtask

  task automatic test_first_spin;
    int prev_t;
    int extra;
    rst = 1'b0;
    start_spin();
    measure(-1, -1, -1, -1);
    checks++; if (run_cycles != 340) begin errors++; $display("FAIL first_run_cycles got %0d want 340", run_cycles); end
    checks++; if (step_t.size() != 17) begin errors++; $display("FAIL first_steps got %0d want 17", step_t.size()); end
    prev_t = 0;
    for (int k = 0; k < step_t.size(); k++) begin
      checks++;
      if (step_t[k] - prev_t != 4 + 2 * k) begin
        errors++; $display("FAIL first_spacing step %0d got %0d want %0d", k, step_t[k] - prev_t, 4 + 2 * k);
      end
      checks++;
      if (step_p[k] != (k + 1) % 6) begin
        errors++; $display("FAIL first_pos step %0d got %0d want %0d", k, step_p[k], (k + 1) % 6);
      end
      prev_t = step_t[k];
    end
    checks++; if (sif.pos_o !== 3'd5) begin errors++; $display("FAIL first_final_pos got %0d want 5", sif.pos_o); end
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (sif.done_o === 1'b1) extra++;
    end
    checks++; if (dones + extra != 1) begin errors++; $display("FAIL first_done_pulses got %0d want 1", dones + extra); end
  endtask

  task automatic test_wrap;
    int prev_t;
    start_spin();
    measure(-1, -1, -1, -1);
    checks++; if (step_t.size() != exp_steps) begin errors++; $display("FAIL wrap_steps got %0d want %0d", step_t.size(), exp_steps); end
    checks++; if (step_t.size() < 1 || step_p[0] != 0) begin errors++; $display("FAIL wrap_first_pos got %0d want 0", step_t.size() > 0 ? step_p[0] : -1); end
    prev_t = 0;
    for (int k = 0; k < step_t.size(); k++) begin
      checks++;
      if (step_p[k] != (5 + k + 1) % 6 || step_t[k] - prev_t != 4 + 2 * k) begin
        errors++; $display("FAIL wrap_step %0d got pos %0d gap %0d want pos %0d gap %0d",
                           k, step_p[k], step_t[k] - prev_t, (6 + k) % 6, 4 + 2 * k);
      end
      prev_t = step_t[k];
    end
    checks++; if (run_cycles != spin_len(exp_steps)) begin errors++; $display("FAIL wrap_run_cycles got %0d want %0d", run_cycles, spin_len(exp_steps)); end
  endtask

  task automatic test_back_to_back;
    int p0;
    checks++; if (sif.done_o !== 1'b1) begin errors++; $display("FAIL b2b_done_present got %0b want 1", sif.done_o); end
    p0 = int'(sif.pos_o);
    start_spin();
    checks++; if (sif.running_o !== 1'b1) begin errors++; $display("FAIL b2b_restart got %0b want 1", sif.running_o); end
    measure(-1, -1, -1, -1);
    checks++; if (step_t.size() != exp_steps) begin errors++; $display("FAIL b2b_steps got %0d want %0d", step_t.size(), exp_steps); end
    checks++; if (run_cycles != spin_len(exp_steps)) begin errors++; $display("FAIL b2b_run_cycles got %0d want %0d", run_cycles, spin_len(exp_steps)); end
    checks++; if (int'(sif.pos_o) != (p0 + exp_steps) % 6) begin errors++; $display("FAIL b2b_final_pos got %0d want %0d", sif.pos_o, (p0 + exp_steps) % 6); end
    tick();
  endtask

  task automatic test_start_ignored;
    int p0;
    p0 = int'(sif.pos_o);
    start_spin();
    measure(10, 50, 200, -1);
    checks++; if (step_t.size() != exp_steps) begin errors++; $display("FAIL ign_steps got %0d want %0d", step_t.size(), exp_steps); end
    checks++; if (run_cycles != spin_len(exp_steps)) begin errors++; $display("FAIL ign_run_cycles got %0d want %0d", run_cycles, spin_len(exp_steps)); end
    checks++; if (int'(sif.pos_o) != (p0 + exp_steps) % 6) begin errors++; $display("FAIL ign_final_pos got %0d want %0d", sif.pos_o, (p0 + exp_steps) % 6); end
    checks++; if (dones != 1) begin errors++; $display("FAIL ign_done_pulses got %0d want 1", dones); end
    tick();
  endtask

  task automatic test_reset_mid;
    int late_done;
    int late_run;
    start_spin();
    for (int i = 0; i < 99; i++) tick();
    rst = 1'b1;
    tick();
    checks++; if (sif.pos_o !== 3'd0) begin errors++; $display("FAIL midrst_pos got %0d want 0", sif.pos_o); end
    checks++; if (sif.running_o !== 1'b0) begin errors++; $display("FAIL midrst_running got %0b want 0", sif.running_o); end
    checks++; if (sif.done_o !== 1'b0) begin errors++; $display("FAIL midrst_done got %0b want 0", sif.done_o); end
    rst = 1'b0;
    late_done = 0;
    late_run = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (sif.done_o === 1'b1) late_done++;
      if (sif.running_o === 1'b1) late_run++;
    end
    checks++; if (late_done != 0) begin errors++; $display("FAIL midrst_late_done got %0d want 0", late_done); end
    checks++; if (late_run != 0) begin errors++; $display("FAIL midrst_late_running got %0d want 0", late_run); end
  endtask

`ifdef SPIN_STOP_EN
  task automatic test_stop;
    int before;
    start_spin();
    measure(-1, -1, -1, 30);
    before = 0;
    foreach (step_t[k]) if (step_t[k] <= 30) before++;
    checks++; if (step_t.size() != before + 2) begin errors++; $display("FAIL stop_steps got %0d want %0d", step_t.size(), before + 2); end
    checks++; if (run_cycles != spin_len(before + 2)) begin errors++; $display("FAIL stop_run_cycles got %0d want %0d", run_cycles, spin_len(before + 2)); end
    checks++; if (dones != 1) begin errors++; $display("FAIL stop_done_pulses got %0d want 1", dones); end
    tick();
  endtask
`endif

  initial begin
    sif.start_i = 1'b0;
`ifdef SPIN_STOP_EN
    sif.stop_i = 1'b0;
`endif
    test_reset();
    test_first_spin();
    test_wrap();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
`ifdef SPIN_STOP_EN
    test_stop();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
